mtx_mvmul_engine: RTL and testbench
===================================

Name: mtx_mvmul_engine

Overview:
- Parametrised, multi-cycle ternary matrix × fixed-point vector multiplier; the dedicated execution unit behind the MVMUL opcode.
- Computes y[r] = sat( sum over c of mul3(M[r][c], x[c]) ) for all rows, processing LANES columns per cycle.
- Optionally accumulates onto the previous result, y += M·x.
- Sits between the M0/V0 register files and the VLIW issue stage, with valid/ready handshakes on both sides.

Parameters:
- ROWS, 16, matrix rows and output vector length.
- COLS, 16, matrix columns and input vector length; must be a multiple of LANES.
- DW, 32, signed fixed-point element width (Q(DW-1)).
- LANES, 4, columns consumed per cycle; 1 ≤ LANES ≤ COLS.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand bundle valid
- in_ready  out  1  engine can accept operands
- in_acc  in  1  1 = accumulate onto the held result, 0 = overwrite
- in_mtx  in  2*ROWS*COLS  ternary matrix, element [r][c] at bits 2*(r*COLS+c)+:2
- in_vec  in  DW*COLS  input vector, element c at bits DW*c+:DW
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_vec  out  DW*ROWS  saturated result vector
- out_status  out  4  {of, uf, zero, inv}

Behaviour:
- Ternary codes: 00 = 0, 01 = +1, 10 = −1, 11 = invalid. An invalid code contributes 0 and sets inv.
- Accumulator width: ACCW = DW + clog2(COLS) + 2.
  - Operands are sign-extended to ACCW before any negation, so −2^(DW−1) negates exactly.
- Reset values: state IDLE, in_ready = 1, out_valid = 0, out_vec = 0, out_status = 0, accumulators = 0, column counter = 0.
- FSM IDLE:
  - in_ready = 1.
  - On in_valid: latch in_mtx, in_vec and in_acc.
  - Preload accumulators with sign-extended out_vec if in_acc = 1, else with 0.
  - Clear the sticky inv flag; go to RUN.
- FSM RUN:
  - in_ready = 0.
  - Each cycle, add the LANES contributions for columns [k*LANES, k*LANES+LANES−1] to every row accumulator; k increments.
  - After the last beat (k = COLS/LANES − 1), go to SAT.
- FSM SAT:
  - Saturate each accumulator to DW bits: above 2^(DW−1)−1 → max, set of; below −2^(DW−1) → min, set uf.
  - Register out_vec and out_status. zero = all out_vec elements are 0.
  - out_valid = 1; go to DONE.
- FSM DONE:
  - out_valid held and out_vec stable until out_ready.
  - On out_valid && out_ready: out_valid → 0, go to IDLE. out_vec and out_status are retained for a later in_acc.
- Latency: in-handshake to out_valid = COLS/LANES + 1 cycles.
  - With defaults this is 5 cycles.
  - Throughput: one operation per COLS/LANES + 3 cycles.
- Handshake rules:
  - in_valid while in_ready = 0 is ignored; the source must hold it.
  - The cycle of the output handshake does not also accept input; the new operation is accepted the next cycle.
- of, uf and inv are per-operation, not sticky across operations.
- Reset asserted mid-operation aborts immediately to the reset values; no partial result appears.
- out_ready high while out_valid = 0 has no effect.

Optional Feature:
- Macro: MTX_MVMUL_RELU_EN.
- When defined:
  - Adds input port in_relu (1 bit), latched with the operands.
  - In SAT, elements negative after saturation are forced to 0.
  - zero is evaluated after the ReLU; uf is still reported from the pre-ReLU value.
- When undefined: the port is absent and there is no clamp logic.

Decomposition:
- Shared package (mtx_types):
  - val3_t and its encodings.
  - status_t field order {of, uf, zero, inv}.
  - A parametrised saturation helper.
  - Ternary-multiply helper extended to ACCW with invalid detection.
  - ACCW derivation as a localparam function.
- One sub-module: mtx_mvmul_lane_row.
  - One row's LANES-wide ternary adder tree plus accumulator register.
  - Instantiated ROWS times by a generate loop.

Test Plan:
- Identity: M = +1 on the diagonal, 00 elsewhere, x[c] = c*1000 → out_vec[r] = r*1000, status = 0000, out_valid exactly 5 cycles after the in-handshake.
- Negation and invalid: row 0 all 10, x all 0x00000001; row 1 with one code 11 and the rest 00 → out[0] = −16, out[1] = 0, inv = 1.
- Saturation:
  - All +1, x all 0x7FFFFFFF → every out = 0x7FFFFFFF, of = 1.
  - All −1, same x → 0x80000000, uf = 1.
  - All −1, x all 0x80000000 → 0x7FFFFFFF, of = 1.
- Accumulate: run the identity case, then repeat with in_acc = 1 → out[r] = r*2000. Hold out_ready low for 10 cycles and check out_vec stays stable.
- Reset abort: assert rst_n = 0 during RUN beat 2 → out_valid = 0, out_vec = 0, in_ready = 1; the next op without in_acc completes correctly.
- Parameters LANES = 1 and LANES = 16 with random ternary matrix and vector → results match the reference model; latency is 17 and 2 cycles respectively. With MTX_MVMUL_RELU_EN and in_relu = 1, negative outputs read 0.

Source files
------------

// File: rtl/mtx_types_pkg.sv
//============================================================================
// Module      : mtx_types (package)
// Description : Shared types and helpers for the ternary matrix x vector
//               multiplier: ternary codes, status word, FSM states,
//               accumulator width, ternary multiply and saturation.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

package mtx_types;

   // Internal width used by the helpers; callers size results down.
   localparam int MAXW = 128;

   typedef enum logic [1:0] {
      V3_ZERO = 2'b00,
      V3_POS  = 2'b01,
      V3_NEG  = 2'b10,
      V3_INV  = 2'b11
   } val3_t;

   typedef struct packed {
      logic of;
      logic uf;
      logic zero;
      logic inv;
   } status_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_SAT  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Accumulator width: enough headroom for COLS terms plus a preloaded value.
   function automatic int accw_calc(input int dw, input int cols);
      return dw + $clog2(cols) + 2;
   endfunction

   // Ternary multiply of an already sign-extended operand; an invalid code
   // contributes zero and raises inv.
   function automatic logic signed [MAXW-1:0] mul3(input val3_t code,
                                                   input logic signed [MAXW-1:0] x,
                                                   output logic inv);
      logic signed [MAXW-1:0] res;
      inv = 1'b0;
      res = '0;
      case (code)
         V3_POS:  res = x;
         V3_NEG:  res = -x;
         V3_INV:  inv = 1'b1;
         default: res = '0;
      endcase
      return res;
   endfunction

   // Clamp a wide signed value into the signed dw-bit range.
   function automatic logic signed [MAXW-1:0] sat_to_dw(input logic signed [MAXW-1:0] acc,
                                                        input int dw,
                                                        output logic of,
                                                        output logic uf);
      logic signed [MAXW-1:0] hi;
      logic signed [MAXW-1:0] lo;
      logic signed [MAXW-1:0] res;
      hi  = (MAXW'(1) << (dw - 1)) - MAXW'(1);
      lo  = ~hi;
      of  = (acc > hi);
      uf  = (acc < lo);
      res = of ? hi : (uf ? lo : acc);
      return res;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mtx_mvmul_lane_row.sv
//============================================================================
// Module      : mtx_mvmul_lane_row
// Description : One matrix row: sums LANES ternary products per beat and
//               accumulates them into a row accumulator.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module mtx_mvmul_lane_row
   import mtx_types::*;
#(
   parameter int DW    = 32,
   parameter int LANES = 4,
   parameter int ACCW  = 38
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic                  beat,
   input  logic [ACCW-1:0]       preload,
   input  logic [2*LANES-1:0]    codes,
   input  logic [DW*LANES-1:0]   xs,
   output logic [ACCW-1:0]       acc,
   output logic                  inv
);

   logic [ACCW-1:0]        beat_sum;
   logic signed [MAXW-1:0] xw;
   logic                   lane_inv;

   // Sum of this beat's LANES contributions, with invalid-code detection.
   always_comb begin
      beat_sum = '0;
      inv      = 1'b0;
      xw       = '0;
      lane_inv = 1'b0;
      for (int l = 0; l < LANES; l++) begin
         // Sign-extend before negation so the most negative input negates exactly.
         xw       = {{(MAXW-DW){xs[DW*l+DW-1]}}, xs[DW*l +: DW]};
         beat_sum = beat_sum + ACCW'(mul3(val3_t'(codes[2*l +: 2]), xw, lane_inv));
         inv      = inv | lane_inv;
      end
   end

   // Row accumulator: preload on operation start, add one beat per RUN cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (load) begin
         acc <= preload;
      end else if (beat) begin
         acc <= acc + beat_sum;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mtx_mvmul_engine.sv
//============================================================================
// Module      : mtx_mvmul_engine
// Description : Multi-cycle ternary matrix x fixed-point vector multiplier
//               with optional accumulate (y += M.x) and saturating output.
//               Optional feature macro: MTX_MVMUL_RELU_EN adds in_relu and
//               clamps negative results to zero.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module mtx_mvmul_engine
   import mtx_types::*;
#(
   parameter int ROWS  = 16,
   parameter int COLS  = 16,
   parameter int DW    = 32,
   parameter int LANES = 4
)
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_acc,
`ifdef MTX_MVMUL_RELU_EN
   input  logic                     in_relu,
`endif
   input  logic [2*ROWS*COLS-1:0]   in_mtx,
   input  logic [DW*COLS-1:0]       in_vec,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DW*ROWS-1:0]       out_vec,
   output logic [3:0]               out_status
);

   localparam int              ACCW   = accw_calc(DW, COLS);
   localparam int              BEATS  = COLS / LANES;
   localparam int              KW     = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [KW-1:0]   K_LAST = KW'(BEATS - 1);

   state_t                  state;
   state_t                  state_nxt;
   logic                    accept;
   logic                    beat;
   logic [KW-1:0]           k;
   logic [31:0]             kcol;
   logic [2*ROWS*COLS-1:0]  mtx_q;
   logic [DW*COLS-1:0]      vec_q;
   logic [DW*LANES-1:0]     lane_x;
   logic                    inv_q;
   logic [ROWS-1:0]         row_inv;
   logic [ACCW-1:0]         acc_arr [ROWS];
   logic [DW*ROWS-1:0]      sat_vec;
   logic                    sat_of;
   logic                    sat_uf;
   logic                    r_of;
   logic                    r_uf;
   logic [DW-1:0]           el;
   status_t                 status_q;
`ifdef MTX_MVMUL_RELU_EN
   logic                    relu_q;
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next-state and handshake outputs.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      beat      = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept    = 1'b1;
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            beat = 1'b1;
            if (k == K_LAST) begin
               state_nxt = ST_SAT;
            end
         end
         ST_SAT: begin
            state_nxt = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            // The output handshake cycle returns to IDLE without accepting input.
            if (out_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Column-group counter, one step per RUN beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k <= '0;
      end else if (accept) begin
         k <= '0;
      end else if (beat) begin
         k <= (k == K_LAST) ? '0 : k + 1'b1;
      end
   end

   // Operand capture at the input handshake; contents are don't-care until then.
   always_ff @(posedge clk) begin
      if (accept) begin
         mtx_q  <= in_mtx;
         vec_q  <= in_vec;
`ifdef MTX_MVMUL_RELU_EN
         relu_q <= in_relu;
`endif
      end
   end

   // Per-operation invalid-code flag, cleared at each new operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inv_q <= 1'b0;
      end else if (accept) begin
         inv_q <= 1'b0;
      end else if (beat) begin
         inv_q <= inv_q | (|row_inv);
      end
   end

   assign kcol   = 32'(k) * 32'(LANES);
   assign lane_x = vec_q[DW*kcol +: DW*LANES];

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      logic [ACCW-1:0] pre;

      // Accumulate mode starts from the retained, sign-extended previous result.
      assign pre = in_acc ? {{(ACCW-DW){out_vec[DW*r+DW-1]}}, out_vec[DW*r +: DW]} : '0;

      mtx_mvmul_lane_row #(
         .DW    (DW),
         .LANES (LANES),
         .ACCW  (ACCW)
      ) u_row (
         .clk     (clk),
         .rst_n   (rst_n),
         .load    (accept),
         .beat    (beat),
         .preload (pre),
         .codes   (mtx_q[2*r*COLS + 2*kcol +: 2*LANES]),
         .xs      (lane_x),
         .acc     (acc_arr[r]),
         .inv     (row_inv[r])
      );
   end

   // Saturate every accumulator to DW bits (and optionally clamp negatives).
   always_comb begin
      sat_vec = '0;
      sat_of  = 1'b0;
      sat_uf  = 1'b0;
      r_of    = 1'b0;
      r_uf    = 1'b0;
      el      = '0;
      for (int r = 0; r < ROWS; r++) begin
         el = DW'(sat_to_dw({{(MAXW-ACCW){acc_arr[r][ACCW-1]}}, acc_arr[r]}, DW, r_of, r_uf));
         sat_of = sat_of | r_of;
         sat_uf = sat_uf | r_uf;
`ifdef MTX_MVMUL_RELU_EN
         if (relu_q && el[DW-1]) begin
            el = '0;
         end
`endif
         sat_vec[DW*r +: DW] = el;
      end
   end

   // Result and status registers; retained after the output handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vec  <= '0;
         status_q <= '0;
      end else if (state == ST_SAT) begin
         out_vec       <= sat_vec;
         status_q.of   <= sat_of;
         status_q.uf   <= sat_uf;
         status_q.zero <= (sat_vec == '0);
         status_q.inv  <= inv_q;
      end
   end

   assign out_status = status_q;

endmodule

`default_nettype wire

// File: tb/tb_mtx_mvmul_engine.sv
//============================================================================
// Module      : tb_mtx_mvmul_engine
// Description : Self-checking bench for mtx_mvmul_engine with a scoreboard
//               of reference-model results.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mtx_mvmul_engine;

   localparam int ROWS = 16;
   localparam int COLS = 16;
   localparam int DW   = 32;
   localparam int MW   = 2*ROWS*COLS;
   localparam int VW   = DW*COLS;
   localparam int OW   = DW*ROWS;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic          in_acc;
`ifdef MTX_MVMUL_RELU_EN
   logic          in_relu;
`endif
   logic [MW-1:0] in_mtx;
   logic [VW-1:0] in_vec;
   logic          out_valid;
   logic          out_ready;
   logic [OW-1:0] out_vec;
   logic [3:0]    out_status;

   logic          lv_valid;
   logic          lv_ready;
   logic          l1_in_ready, l16_in_ready;
   logic          l1_valid, l16_valid;
   logic [OW-1:0] l1_vec, l16_vec;
   logic [3:0]    l1_st, l16_st;

   typedef struct {
      logic [OW-1:0] vec;
      logic [3:0]    st;
   } exp_t;

   exp_t          sb_q[$];
   logic [OW-1:0] model_prev;
   logic [MW-1:0] id_m;
   logic [VW-1:0] id_v;
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   mtx_mvmul_engine #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .LANES(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc),
`ifdef MTX_MVMUL_RELU_EN
      .in_relu(in_relu),
`endif
      .in_mtx(in_mtx), .in_vec(in_vec), .out_valid(out_valid), .out_ready(out_ready),
      .out_vec(out_vec), .out_status(out_status));

   mtx_mvmul_engine #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .LANES(1)) u_l1 (
      .clk(clk), .rst_n(rst_n), .in_valid(lv_valid), .in_ready(l1_in_ready), .in_acc(in_acc),
`ifdef MTX_MVMUL_RELU_EN
      .in_relu(in_relu),
`endif
      .in_mtx(in_mtx), .in_vec(in_vec), .out_valid(l1_valid), .out_ready(lv_ready),
      .out_vec(l1_vec), .out_status(l1_st));

   mtx_mvmul_engine #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .LANES(16)) u_l16 (
      .clk(clk), .rst_n(rst_n), .in_valid(lv_valid), .in_ready(l16_in_ready), .in_acc(in_acc),
`ifdef MTX_MVMUL_RELU_EN
      .in_relu(in_relu),
`endif
      .in_mtx(in_mtx), .in_vec(in_vec), .out_valid(l16_valid), .out_ready(lv_ready),
      .out_vec(l16_vec), .out_status(l16_st));

   // Reference: exact 64-bit sums, then saturation, optional ReLU, status.
   function automatic void ref_mvmul(input logic [MW-1:0] m, input logic [VW-1:0] v,
                                     input logic acc, input logic relu,
                                     input logic [OW-1:0] prev,
                                     output logic [OW-1:0] y, output logic [3:0] st);
      longint     s, xv;
      logic [1:0] code;
      logic [31:0] el;
      logic       of, uf, inv;
      of = 1'b0; uf = 1'b0; inv = 1'b0; y = '0;
      for (int r = 0; r < ROWS; r++) begin
         s = acc ? longint'($signed(prev[DW*r +: DW])) : 64'sd0;
         for (int c = 0; c < COLS; c++) begin
            code = m[2*(r*COLS+c) +: 2];
            xv   = longint'($signed(v[DW*c +: DW]));
            case (code)
               2'b01:   s = s + xv;
               2'b10:   s = s - xv;
               2'b11:   inv = 1'b1;
               default: ;
            endcase
         end
         if (s > 64'sd2147483647) begin
            el = 32'h7FFF_FFFF; of = 1'b1;
         end else if (s < -64'sd2147483648) begin
            el = 32'h8000_0000; uf = 1'b1;
         end else begin
            el = s[31:0];
         end
         if (relu && el[31]) el = '0;
         y[DW*r +: DW] = el;
      end
      st = {of, uf, (y == '0), inv};
   endfunction

   function automatic logic [MW-1:0] rand_mtx();
      logic [MW-1:0] m;
      for (int i = 0; i < ROWS*COLS; i++) begin
         m[2*i +: 2] = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      end
      return m;
   endfunction

   function automatic logic [VW-1:0] rand_vec();
      logic [VW-1:0] v;
      for (int c = 0; c < COLS; c++) v[DW*c +: DW] = $urandom;
      return v;
   endfunction

   task automatic send_op(input logic [MW-1:0] m, input logic [VW-1:0] v,
                          input logic acc, input logic relu);
      exp_t e;
      ref_mvmul(m, v, acc, relu, model_prev, e.vec, e.st);
      model_prev = e.vec;
      sb_q.push_back(e);
      @(negedge clk);
      in_mtx = m; in_vec = v; in_acc = acc;
`ifdef MTX_MVMUL_RELU_EN
      in_relu = relu;
`endif
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask

   task automatic release_out();
      @(negedge clk) out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (out_vec !== '0) begin errors++; $display("FAIL reset_out_vec: got %h want 0", out_vec); end
      checks++; if (out_status !== 4'b0000) begin errors++; $display("FAIL reset_status: got %b want 0000", out_status); end
   endtask

   task automatic test_identity();
      int   lat;
      exp_t e;
      id_m = '0;
      for (int r = 0; r < ROWS; r++) id_m[2*(r*COLS+r) +: 2] = 2'b01;
      for (int c = 0; c < COLS; c++) id_v[DW*c +: DW] = 32'(c*1000);
      send_op(id_m, id_v, 1'b0, 1'b0);
      wait_out(lat);
      e = sb_q.pop_front();
      checks++; if (lat !== 5) begin errors++; $display("FAIL identity_latency: got %0d want 5", lat); end
      checks++; if (out_vec !== e.vec) begin errors++; $display("FAIL identity_vec: got %h want %h", out_vec, e.vec); end
      checks++; if (out_vec[DW*7 +: DW] !== 32'd7000) begin errors++; $display("FAIL identity_row7: got %0d want 7000", out_vec[DW*7 +: DW]); end
      checks++; if (out_status !== 4'b0000) begin errors++; $display("FAIL identity_status: got %b want 0000", out_status); end
      release_out();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL identity_valid_drop: got %b want 0", out_valid); end
   endtask

   task automatic test_accumulate();
      int            lat;
      exp_t          e;
      logic [OW-1:0] snap;
      send_op(id_m, id_v, 1'b1, 1'b0);
      wait_out(lat);
      e = sb_q.pop_front();
      checks++; if (lat !== 5) begin errors++; $display("FAIL acc_latency: got %0d want 5", lat); end
      snap = out_vec;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checks++;
         if (out_vec !== snap || out_valid !== 1'b1) begin
            errors++; $display("FAIL acc_hold cycle %0d: got valid=%b vec=%h want valid=1 vec=%h", i, out_valid, out_vec, snap);
         end
      end
      checks++; if (out_vec !== e.vec) begin errors++; $display("FAIL acc_vec: got %h want %h", out_vec, e.vec); end
      checks++; if (out_vec[DW*15 +: DW] !== 32'd30000) begin errors++; $display("FAIL acc_row15: got %0d want 30000", out_vec[DW*15 +: DW]); end
      release_out();
   endtask

   task automatic test_neg_invalid();
      int            lat;
      exp_t          e;
      logic [MW-1:0] m;
      logic [VW-1:0] v;
      m = '0;
      for (int c = 0; c < COLS; c++) begin
         m[2*c +: 2]   = 2'b10;
         v[DW*c +: DW] = 32'h0000_0001;
      end
      m[2*(COLS+5) +: 2] = 2'b11;
      send_op(m, v, 1'b0, 1'b0);
      wait_out(lat);
      e = sb_q.pop_front();
      checks++; if (out_vec !== e.vec) begin errors++; $display("FAIL neginv_vec: got %h want %h", out_vec, e.vec); end
      checks++; if (out_vec[0 +: DW] !== 32'hFFFF_FFF0) begin errors++; $display("FAIL neginv_row0: got %h want fffffff0", out_vec[0 +: DW]); end
      checks++; if (out_vec[DW +: DW] !== 32'h0) begin errors++; $display("FAIL neginv_row1: got %h want 0", out_vec[DW +: DW]); end
      checks++; if (out_status !== e.st || out_status[0] !== 1'b1) begin errors++; $display("FAIL neginv_status: got %b want %b", out_status, e.st); end
      release_out();
   endtask

   task automatic test_saturation();
      logic [1:0]  code [3] = '{2'b01, 2'b10, 2'b10};
      logic [31:0] xval [3] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
      logic [31:0] want [3] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
      logic [3:0]  wst  [3] = '{4'b1000, 4'b0100, 4'b1000};
      int            lat;
      exp_t          e;
      logic [MW-1:0] m;
      logic [VW-1:0] v;
      for (int t = 0; t < 3; t++) begin
         for (int i = 0; i < ROWS*COLS; i++) m[2*i +: 2] = code[t];
         for (int c = 0; c < COLS; c++) v[DW*c +: DW] = xval[t];
         send_op(m, v, 1'b0, 1'b0);
         wait_out(lat);
         e = sb_q.pop_front();
         checks++; if (out_vec !== e.vec) begin errors++; $display("FAIL sat%0d_vec: got %h want %h", t, out_vec, e.vec); end
         checks++; if (out_vec[DW*9 +: DW] !== want[t]) begin errors++; $display("FAIL sat%0d_row9: got %h want %h", t, out_vec[DW*9 +: DW], want[t]); end
         checks++; if (out_status !== wst[t]) begin errors++; $display("FAIL sat%0d_status: got %b want %b", t, out_status, wst[t]); end
         release_out();
      end
   endtask

   task automatic test_back_to_back();
      int            lat;
      exp_t          ea, eb, e;
      logic [MW-1:0] ma, mb;
      logic [VW-1:0] va, vb;
      ma = rand_mtx(); va = rand_vec(); mb = rand_mtx(); vb = rand_vec();
      ref_mvmul(ma, va, 1'b0, 1'b0, model_prev, ea.vec, ea.st);
      ref_mvmul(mb, vb, 1'b1, 1'b0, ea.vec, eb.vec, eb.st);
      model_prev = eb.vec;
      sb_q.push_back(ea);
      sb_q.push_back(eb);
      @(negedge clk);
      in_mtx = ma; in_vec = va; in_acc = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_mtx = mb; in_vec = vb; in_acc = 1'b1;
      wait_out(lat);
      e = sb_q.pop_front();
      checks++; if (lat !== 5) begin errors++; $display("FAIL b2b_latency_a: got %0d want 5", lat); end
      checks++; if (out_vec !== e.vec || out_status !== e.st) begin errors++; $display("FAIL b2b_result_a: got %h/%b want %h/%b", out_vec, out_status, e.vec, e.st); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy: got in_ready=%b want 0", in_ready); end
      release_out();
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got ready=%b valid=%b want 1/0", in_ready, out_valid); end
      @(posedge clk);
      #1 in_valid = 1'b0;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept_b: got in_ready=%b want 0", in_ready); end
      wait_out(lat);
      e = sb_q.pop_front();
      checks++; if (lat !== 5) begin errors++; $display("FAIL b2b_latency_b: got %0d want 5", lat); end
      checks++; if (out_vec !== e.vec || out_status !== e.st) begin errors++; $display("FAIL b2b_result_b: got %h/%b want %h/%b", out_vec, out_status, e.vec, e.st); end
      release_out();
   endtask

   task automatic test_reset_abort();
      int   lat;
      exp_t e;
      send_op(rand_mtx(), rand_vec(), 1'b0, 1'b0);
      void'(sb_q.pop_back());
      @(posedge clk);
      @(negedge clk) rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL abort_ctrl: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
      checks++; if (out_vec !== '0 || out_status !== 4'b0) begin errors++; $display("FAIL abort_data: got %h/%b want 0/0000", out_vec, out_status); end
      @(negedge clk) rst_n = 1'b1;
      model_prev = '0;
      repeat (8) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_no_partial: got valid=%b want 0", out_valid); end
      send_op(rand_mtx(), rand_vec(), 1'b0, 1'b0);
      wait_out(lat);
      e = sb_q.pop_front();
      checks++; if (lat !== 5) begin errors++; $display("FAIL abort_next_latency: got %0d want 5", lat); end
      checks++; if (out_vec !== e.vec || out_status !== e.st) begin errors++; $display("FAIL abort_next_result: got %h/%b want %h/%b", out_vec, out_status, e.vec, e.st); end
      release_out();
   endtask

   task automatic test_lanes();
      int            n, lat1, lat16;
      exp_t          e;
      logic [MW-1:0] m;
      logic [VW-1:0] v;
      for (int t = 0; t < 3; t++) begin
         m = rand_mtx(); v = rand_vec();
         ref_mvmul(m, v, 1'b0, 1'b0, '0, e.vec, e.st);
         sb_q.push_back(e);
         checks++; if (l1_in_ready !== 1'b1 || l16_in_ready !== 1'b1) begin errors++; $display("FAIL lanes%0d_ready: got %b/%b want 1/1", t, l1_in_ready, l16_in_ready); end
         @(negedge clk);
         in_mtx = m; in_vec = v; in_acc = 1'b0;
`ifdef MTX_MVMUL_RELU_EN
         in_relu = 1'b0;
`endif
         lv_valid = 1'b1;
         @(posedge clk);
         #1 lv_valid = 1'b0;
         n = 0; lat1 = 0; lat16 = 0;
         while ((!l1_valid || !l16_valid) && n < 100) begin
            @(posedge clk);
            #1 n++;
            if (l1_valid && lat1 == 0) lat1 = n;
            if (l16_valid && lat16 == 0) lat16 = n;
         end
         e = sb_q.pop_front();
         checks++; if (lat1 !== 17) begin errors++; $display("FAIL lanes1_latency: got %0d want 17", lat1); end
         checks++; if (lat16 !== 2) begin errors++; $display("FAIL lanes16_latency: got %0d want 2", lat16); end
         checks++; if (l1_vec !== e.vec || l1_st !== e.st) begin errors++; $display("FAIL lanes1_result: got %h/%b want %h/%b", l1_vec, l1_st, e.vec, e.st); end
         checks++; if (l16_vec !== e.vec || l16_st !== e.st) begin errors++; $display("FAIL lanes16_result: got %h/%b want %h/%b", l16_vec, l16_st, e.vec, e.st); end
         @(negedge clk) lv_ready = 1'b1;
         @(posedge clk);
         #1 lv_ready = 1'b0;
      end
   endtask

`ifdef MTX_MVMUL_RELU_EN
   task automatic test_relu();
      int   lat;
      exp_t e;
      for (int t = 0; t < 2; t++) begin
         send_op(rand_mtx(), rand_vec(), 1'b0, 1'b1);
         wait_out(lat);
         e = sb_q.pop_front();
         checks++; if (out_vec !== e.vec || out_status !== e.st) begin errors++; $display("FAIL relu%0d_result: got %h/%b want %h/%b", t, out_vec, out_status, e.vec, e.st); end
         release_out();
      end
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_acc = 1'b0; out_ready = 1'b0;
      lv_valid = 1'b0; lv_ready = 1'b0; in_mtx = '0; in_vec = '0;
`ifdef MTX_MVMUL_RELU_EN
      in_relu = 1'b0;
`endif
      model_prev = '0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      test_reset();
      test_identity();
      test_accumulate();
      test_neg_invalid();
      test_saturation();
      test_back_to_back();
      test_reset_abort();
      test_lanes();
`ifdef MTX_MVMUL_RELU_EN
      test_relu();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
